wb_burst_fetch: RTL and testbench

Synthesizable Wishbone B3 classic-cycle master that sits directly upstream of the Wishbone slave port.
- Drives CYC/STB/ADR/SEL/WE and consumes ACK/ERR/RTY/DAT from that port.
- Fetches a programmed run of 32-bit words from consecutive addresses into an internal FIFO.
- Presents the words to a downstream valid/ready consumer (pixel/line pipeline).

---
 rtl/wb_burst_fetch_pkg.sv | 23 ++
 rtl/wb_fetch_fifo.sv | 73 +++++++
 rtl/wb_burst_fetch.sv | 205 ++++++++++++++++++++
 tb/tb_wb_burst_fetch.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_burst_fetch_pkg.sv
// -----------------------------------------------------------------------------
// wb_burst_fetch_pkg
// Shared types and constants for the Wishbone burst-fetch master.
//   fetch_state_e : master FSM states (IDLE, REQ, HOLD, BACKOFF)
//   WB_SEL_ALL    : full-word byte-select pattern
//   WB_DATA_W     : Wishbone data width
//   WB_ADDR_W     : Wishbone address width
// -----------------------------------------------------------------------------
package wb_burst_fetch_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 32;

  localparam logic [3:0] WB_SEL_ALL = 4'hF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    HOLD    = 2'd2,
    BACKOFF = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/wb_fetch_fifo.sv
// -----------------------------------------------------------------------------
// wb_fetch_fifo
// Synchronous FIFO holding fetched words for the downstream consumer.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (pointers/count only)
//   push_i     : write data_i (taken when not full, or full with a pop)
//   data_i     : write data
//   pop_i      : remove head entry (ignored when empty)
//   data_o     : head entry, forced to 0 while empty
//   empty_o    : no entries
//   full_o     : DEPTH entries
//   free_cnt_o : DEPTH - entries
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module wb_fetch_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   free_cnt_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty_o    = (cnt_q == '0);
  assign full_o     = (cnt_q == (AW+1)'(DEPTH));
  assign free_cnt_o = (AW+1)'(DEPTH) - cnt_q;
  assign data_o     = empty_o ? '0 : mem[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    // NOTE: assign a default before any branch so no path leaves cnt_d unassigned (which would infer a latch).
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: storage has no reset; the empty count already makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/wb_burst_fetch.sv
// -----------------------------------------------------------------------------
// wb_burst_fetch
// Wishbone B3 classic read master: fetches word_cnt words from consecutive
// addresses starting at base_adr into a FIFO and hands them to a valid/ready
// consumer.
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   start/base_adr/word_cnt   : launch a fetch (sampled only when idle)
//   busy/done/err             : status (done is a pulse, err is sticky)
//   CYC_O..WE_O, DAT_I..RTY_I : Wishbone master port
//   pix_data/valid/ready      : downstream stream
// Optional build macro WB_BURST_FETCH_STATS_EN adds saturating counters
// retry_total (RTY responses) and words_total (accepted words).
// -----------------------------------------------------------------------------
module wb_burst_fetch
  import wb_burst_fetch_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_RETRY  = 8,
  parameter int ADDR_STEP  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WB_ADDR_W-1:0] base_adr,
  input  logic [15:0]          word_cnt,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 CYC_O,
  output logic                 STB_O,
  output logic [WB_ADDR_W-1:0] ADR_O,
  output logic [3:0]           SEL_O,
  output logic                 WE_O,
  input  logic [WB_DATA_W-1:0] DAT_I,
  input  logic                 ACK_I,
  input  logic                 ERR_I,
  input  logic                 RTY_I,
`ifdef WB_BURST_FETCH_STATS_EN
  output logic [15:0]          retry_total,
  output logic [31:0]          words_total,
`endif
  output logic [WB_DATA_W-1:0] pix_data,
  output logic                 pix_valid,
  input  logic                 pix_ready
);

  localparam int FW = $clog2(FIFO_DEPTH) + 1;
  localparam int RW = $clog2(MAX_RETRY + 1);

  fetch_state_e         state_q, state_d;
  logic [WB_ADDR_W-1:0] adr_q, adr_d;
  logic [15:0]          rem_q, rem_d;
  logic [RW-1:0]        retry_q, retry_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 push_d, push_q;
  logic [WB_DATA_W-1:0] push_data_q;

  logic                 bus_req;
  logic                 fifo_empty, fifo_full, fifo_pop;
  logic [FW-1:0]        fifo_free, eff_free;

  // An accepted word spends one cycle in push_data_q before entering the
  // FIFO (registered output path), so its slot is reserved here already.
  assign eff_free = fifo_free - FW'(push_q);
  assign bus_req  = (state_q == REQ);

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    rem_d   = rem_q;
    retry_d = retry_q;
    done_d  = 1'b0;
    err_d   = err_q;
    push_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          err_d   = 1'b0;
          retry_d = '0;
          if (word_cnt == 16'd0) begin
            done_d = 1'b1;
          end else begin
            adr_d   = base_adr;
            rem_d   = word_cnt;
            // HOLD doubles as the launch cycle: it gives the one-cycle gap
            // before the first strobe and also checks FIFO space.
            state_d = HOLD;
          end
        end
      end
      REQ: begin
        if (ERR_I) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (RTY_I) begin
          if (retry_q == RW'(MAX_RETRY - 1)) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            retry_d = retry_q + 1'b1;
            state_d = BACKOFF;
          end
        end else if (ACK_I) begin
          push_d  = 1'b1;
          adr_d   = adr_q + WB_ADDR_W'(ADDR_STEP);
          rem_d   = rem_q - 16'd1;
          retry_d = '0;
          if (rem_q == 16'd1) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else if (eff_free == FW'(1)) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (eff_free != '0) state_d = REQ;
      end
      BACKOFF: begin
        state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      adr_q       <= '0;
      rem_q       <= '0;
      retry_q     <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      rem_q   <= rem_d;
      retry_q <= retry_d;
      done_q  <= done_d;
      err_q   <= err_d;
      push_q  <= push_d;
      if (push_d) push_data_q <= DAT_I;
    end
  end

  wb_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WB_DATA_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push_q),
    .data_i     (push_data_q),
    .pop_i      (fifo_pop),
    .data_o     (pix_data),
    .empty_o    (fifo_empty),
    .full_o     (fifo_full),
    .free_cnt_o (fifo_free)
  );

  assign pix_valid = !fifo_empty;
  assign fifo_pop  = pix_valid && pix_ready;

  // Bus outputs decode straight from the async-reset state register, so
  // CYC_O/STB_O fall the instant rst rises.
  assign CYC_O = bus_req;
  assign STB_O = bus_req;
  assign SEL_O = bus_req ? WB_SEL_ALL : 4'h0;
  assign WE_O  = 1'b0;
  assign ADR_O = adr_q;
  assign busy  = (state_q != IDLE);
  assign done  = done_q;
  assign err   = err_q;

  // The reserved-slot scheme must never let a staged word meet a full FIFO.
  no_overflow_a : assert property (@(posedge clk) disable iff (rst)
    !(push_q && fifo_full && !fifo_pop));

`ifdef WB_BURST_FETCH_STATS_EN
  logic [15:0] retry_total_q;
  logic [31:0] words_total_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retry_total_q <= '0;
      words_total_q <= '0;
    end else begin
      if (bus_req && !ERR_I && RTY_I && (retry_total_q != '1))
        retry_total_q <= retry_total_q + 16'd1;
      if (push_d && (words_total_q != '1))
        words_total_q <= words_total_q + 32'd1;
    end
  end

  assign retry_total = retry_total_q;
  assign words_total = words_total_q;
`endif

endmodule

// File: tb/tb_wb_burst_fetch.sv
// -----------------------------------------------------------------------------
// tb_wb_burst_fetch
// Directed bench for wb_burst_fetch with a combinational Wishbone slave whose
// read data is ADR ^ DKEY. The slave always raises ACK; RTY/ERR are layered on
// top so the master's ERR > RTY > ACK priority is exercised too.
// -----------------------------------------------------------------------------
module tb_wb_burst_fetch;

  localparam logic [31:0] DKEY = 32'hC0DE_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_adr;
  logic [15:0] word_cnt;
  logic        busy, done, err;
  logic        CYC_O, STB_O, WE_O;
  logic [31:0] ADR_O, DAT_I;
  logic [3:0]  SEL_O;
  logic        ACK_I, ERR_I, RTY_I;
  logic [31:0] pix_data;
  logic        pix_valid, pix_ready;

  // slave controls (written by the stimulus process only)
  logic        rty_on = 1'b0, err_on = 1'b0;
  logic [31:0] rty_adr = '0;
  int          rty_lim = 0, ack_base = 0, err_idx = 0;

  // monitor state (written by the monitor process only)
  int          n_done = 0, n_rty = 0, n_cyc = 0, ack_total = 0;
  logic [31:0] ack_log[$];
  logic [31:0] rx[$];
  logic [32:0] trace[$];

  int n_checks = 0, n_pass = 0;

  always #5 clk = ~clk;

  wb_burst_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_adr  (base_adr),
    .word_cnt  (word_cnt),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .CYC_O     (CYC_O),
    .STB_O     (STB_O),
    .ADR_O     (ADR_O),
    .SEL_O     (SEL_O),
    .WE_O      (WE_O),
    .DAT_I     (DAT_I),
    .ACK_I     (ACK_I),
    .ERR_I     (ERR_I),
    .RTY_I     (RTY_I),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready)
  );

  wire bus_req = CYC_O & STB_O;
  assign DAT_I = ADR_O ^ DKEY;
  assign ACK_I = bus_req;
  assign RTY_I = bus_req & rty_on & (ADR_O == rty_adr) & (n_rty < rty_lim);
  assign ERR_I = bus_req & err_on & ((ack_total - ack_base) == err_idx);

  always @(posedge clk) begin
    if (!rst) begin
      if (bus_req) begin
        if (RTY_I && !ERR_I) n_rty <= n_rty + 1;
        if (ACK_I && !RTY_I && !ERR_I) begin
          ack_total <= ack_total + 1;
          ack_log.push_back(ADR_O);
        end
      end
      if (busy) trace.push_back(STB_O ? {1'b1, ADR_O} : 33'h0);
      if (CYC_O) n_cyc <= n_cyc + 1;
      if (pix_valid && pix_ready) rx.push_back(pix_data);
      if (done) n_done <= n_done + 1;
    end
  end

  task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%09h, expected 0x%09h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic do_start(input logic [31:0] b, input logic [15:0] c);
    @(negedge clk);
    start = 1'b1; base_adr = b; word_cnt = c;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done) break;
      @(negedge clk);
    end
    check(tag, 33'(done), 33'd1);
  endtask

  function automatic logic [31:0] rx_at(input int idx);
    return (idx < rx.size()) ? rx[idx] : 32'hDEAD_DEAD;
  endfunction

  function automatic logic [31:0] ack_at(input int idx);
    return (idx < ack_log.size()) ? ack_log[idx] : 32'hDEAD_DEAD;
  endfunction

  function automatic logic [32:0] tr_at(input int idx);
    return (idx < trace.size()) ? trace[idx] : 33'h1_DEAD_DEAD;
  endfunction

  initial begin
    int d0, a0, r0, t0, q0, c0;
    logic [32:0] exp_tr [8];

    rst = 1'b1; start = 1'b0; base_adr = '0; word_cnt = '0; pix_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy",  33'(busy), 33'd0);
    check("rst_done",  33'(done), 33'd0);
    check("rst_err",   33'(err), 33'd0);
    check("rst_cyc",   33'({CYC_O, STB_O, WE_O}), 33'd0);
    check("rst_adr",   33'(ADR_O), 33'd0);
    check("rst_valid", 33'(pix_valid), 33'd0);
    check("rst_data",  33'(pix_data), 33'd0);
    rst = 1'b0;
    @(negedge clk);

    // ---- basic fetch, latency ----
    pix_ready = 1'b1;
    d0 = n_done; a0 = ack_log.size(); r0 = rx.size();
    do_start(32'h1000, 16'd4);
    check("basic_busy_n",  33'(busy), 33'd1);
    check("basic_cyc_n",   33'(CYC_O), 33'd0);
    @(negedge clk);
    check("basic_cyc_n1",  33'({CYC_O, STB_O}), 33'd3);
    check("basic_adr0",    33'(ADR_O), 33'h1000);
    check("basic_sel",     33'(SEL_O), 33'hF);
    @(negedge clk);
    check("basic_valid_m", 33'(pix_valid), 33'd0);
    @(negedge clk);
    check("basic_valid_m1", 33'(pix_valid), 33'd1);
    check("basic_data_m1", 33'(pix_data), 33'(32'h1000 ^ DKEY));
    wait_done("basic_done", 20);
    check("basic_busy_end", 33'(busy), 33'd0);
    check("basic_cyc_end", 33'(CYC_O), 33'd0);
    check("basic_err",     33'(err), 33'd0);
    repeat (5) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("basic_adr%0d", i), 33'(ack_at(a0 + i)), 33'(32'h1000 + 4 * i));
      check($sformatf("basic_rx%0d", i), 33'(rx_at(r0 + i)), 33'((32'h1000 + 4 * i) ^ DKEY));
    end
    check("basic_nrx",   33'(rx.size() - r0), 33'd4);
    check("basic_ndone", 33'(n_done - d0), 33'd1);

    // ---- backpressure, plus a start while busy ----
    pix_ready = 1'b0;
    d0 = n_done; a0 = ack_log.size(); r0 = rx.size();
    do_start(32'h3000, 16'd20);
    repeat (40) @(negedge clk);
    check("bp_acks16",  33'(ack_log.size() - a0), 33'd16);
    check("bp_stb_off", 33'(STB_O), 33'd0);
    check("bp_busy",    33'(busy), 33'd1);
    check("bp_valid",   33'(pix_valid), 33'd1);
    do_start(32'h9000, 16'd1);
    pix_ready = 1'b1;
    wait_done("bp_done", 200);
    repeat (20) @(negedge clk);
    check("bp_acks20", 33'(ack_log.size() - a0), 33'd20);
    check("bp_nrx",    33'(rx.size() - r0), 33'd20);
    for (int i = 0; i < 20; i++)
      check($sformatf("bp_rx%0d", i), 33'(rx_at(r0 + i)), 33'((32'h3000 + 4 * i) ^ DKEY));
    check("bp_ndone",  33'(n_done - d0), 33'd1);

    // ---- two retries on 0x2004 ----
    rty_on = 1'b1; rty_adr = 32'h2004; rty_lim = n_rty + 2;
    r0 = rx.size(); t0 = trace.size();
    do_start(32'h2000, 16'd3);
    wait_done("rty_done", 40);
    check("rty_err", 33'(err), 33'd0);
    repeat (4) @(negedge clk);
    exp_tr = '{33'h0, {1'b1, 32'h2000}, {1'b1, 32'h2004}, 33'h0,
               {1'b1, 32'h2004}, 33'h0, {1'b1, 32'h2004}, {1'b1, 32'h2008}};
    check("rty_trace_len", 33'(trace.size() - t0), 33'd8);
    for (int i = 0; i < 8; i++)
      check($sformatf("rty_trace%0d", i), tr_at(t0 + i), exp_tr[i]);
    check("rty_nrx", 33'(rx.size() - r0), 33'd3);
    check("rty_rx1", 33'(rx_at(r0 + 1)), 33'(32'h2004 ^ DKEY));

    // ---- retry limit ----
    rty_adr = 32'h4000; rty_lim = n_rty + 100;
    q0 = n_rty; a0 = ack_log.size();
    do_start(32'h4000, 16'd2);
    wait_done("rlim_done", 60);
    check("rlim_err",  33'(err), 33'd1);
    check("rlim_cyc",  33'(CYC_O), 33'd0);
    check("rlim_busy", 33'(busy), 33'd0);
    @(negedge clk);
    check("rlim_nrty", 33'(n_rty - q0), 33'd8);
    check("rlim_acks", 33'(ack_log.size() - a0), 33'd0);
    rty_on = 1'b0;

    // ---- ERR on word 3 of 5 ----
    pix_ready = 1'b0;
    err_on = 1'b1; ack_base = ack_total; err_idx = 2;
    a0 = ack_log.size(); r0 = rx.size();
    do_start(32'h5000, 16'd5);
    check("errw_cleared", 33'(err), 33'd0);
    wait_done("errw_done", 30);
    check("errw_err", 33'(err), 33'd1);
    check("errw_cyc", 33'(CYC_O), 33'd0);
    err_on = 1'b0;
    repeat (3) @(negedge clk);
    check("errw_acks",  33'(ack_log.size() - a0), 33'd2);
    check("errw_valid", 33'(pix_valid), 33'd1);
    pix_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("errw_nrx", 33'(rx.size() - r0), 33'd2);
    check("errw_rx0", 33'(rx_at(r0)),     33'(32'h5000 ^ DKEY));
    check("errw_rx1", 33'(rx_at(r0 + 1)), 33'(32'h5004 ^ DKEY));

    // ---- word_cnt = 0 ----
    c0 = n_cyc;
    do_start(32'h7000, 16'd0);
    check("zero_done", 33'(done), 33'd1);
    check("zero_busy", 33'(busy), 33'd0);
    check("zero_err",  33'(err), 33'd0);
    repeat (4) @(negedge clk);
    check("zero_nocyc", 33'(n_cyc - c0), 33'd0);

    // ---- address wrap ----
    a0 = ack_log.size(); r0 = rx.size();
    do_start(32'hFFFF_FFFC, 16'd2);
    wait_done("wrap_done", 20);
    repeat (4) @(negedge clk);
    check("wrap_adr0", 33'(ack_at(a0)),     33'hFFFF_FFFC);
    check("wrap_adr1", 33'(ack_at(a0 + 1)), 33'h0);
    check("wrap_rx1",  33'(rx_at(r0 + 1)),  33'(32'h0 ^ DKEY));

    // ---- reset mid-fetch ----
    pix_ready = 1'b0;
    do_start(32'h6000, 16'd10);
    repeat (4) @(negedge clk);
    check("mrst_cyc_before", 33'(CYC_O), 33'd1);
    #3 rst = 1'b1;
    #1;
    check("mrst_cyc",   33'({CYC_O, STB_O}), 33'd0);
    check("mrst_valid", 33'(pix_valid), 33'd0);
    check("mrst_busy",  33'(busy), 33'd0);
    check("mrst_adr",   33'(ADR_O), 33'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("mrst_idle", 33'({busy, CYC_O, pix_valid}), 33'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
